time_setter: RTL and testbench
==============================

# time_setter

User-facing time-entry controller that drives the set side of the real-time clock counter. Button presses edit a packed-BCD hour/minute/second value, seeded from the running clock's current BCD time. While editing, the block holds the counter's enable at the set code so the counter stops and continuously loads `set_hour/set_minute/set_second`. Leaving edit mode releases the counter, which resumes counting from the edited time.

## Interface
- `BLINK_DIV`, default 25_000_000: cycles per blink half-period in edit mode.
- `ENABLE_SET`, default 4'b0100: enable code that stops the counter and loads the set values.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, synchronous and active-low.
- `btn_mode` input 1: debounced level; a rising edge enters or leaves edit mode.
- `btn_next` input 1: debounced level; a rising edge selects the next field.
- `btn_up` input 1: debounced level; a rising edge increments the selected field.
- `btn_down` input 1: debounced level; a rising edge decrements the selected field.
- `cur_h`, `cur_m`, `cur_s` input 8 each: current packed-BCD time from the counter ([7:4] tens, [3:0] units).
- `enable` output 4: mode code to the counter.
- `set_hour`, `set_minute`, `set_second` output 8 each: packed-BCD edit registers.
- `field` output 2: selected field; 0 = hour, 1 = minute, 2 = second, 3 unused.
- `blink` output 1: display-blank strobe for the selected field.

## Operation
- **Edge detection:** one previous-sample register per button. `press_x = btn_x & ~btn_x_q`. The `_q` registers reset to 1, so a button held through reset does not register a press.
- **States:** `IDLE`, `EDIT_H`, `EDIT_M`, `EDIT_S`.
- **IDLE:**
  - `enable` = 4'b0000.
  - `set_*` hold their last values.
  - `press_mode` → `EDIT_H`, and `set_*` capture `cur_*` in that same edge.
  - Capture sanitisation: a field with a digit > 9, hour > 23, or minute/second > 59 is captured as 8'h00.
- **EDIT_x:**
  - `enable` = `ENABLE_SET`.
  - `press_next` moves H → M → S → H.
  - `press_mode` → `IDLE`, with no change to `set_*`.
- **Press priority per cycle:** mode > next > up/down. If up and down are pressed in the same cycle, neither acts.
- **BCD step, selected field only:**
  - Increment: units +1; units 9 → 0 with tens +1. Hour wraps 23 → 00; minute/second wrap 59 → 00.
  - Decrement: units −1; units 0 → 9 with tens −1. Hour wraps 00 → 23; minute/second wrap 00 → 59.
  - Hour wrap 19 → 20 is a normal carry; 09 → 10 likewise.
- **Outputs:**
  - `field` reflects the state: 0 in `IDLE` and `EDIT_H`, 1 in `EDIT_M`, 2 in `EDIT_S`.
  - `blink` toggles every `BLINK_DIV` cycles in edit mode and is 0 in `IDLE`.
  - Any press (next, up, down) or entry into edit clears the blink counter and forces `blink` = 0, so the edited value is visible immediately.

## Timing
- All outputs are registered.
- A press with the level high at edge k and low at edge k−1 takes effect at edge k: the output changes after edge k. Latency is 1 cycle from level rise to output change.
- On entry, `enable` goes to `ENABLE_SET` in the same cycle the capture lands. The counter therefore loads exactly the captured time, with no lost second.
- On exit, `enable` returns to 0 in one cycle. The counter resumes from the last `set_*` value on the following edge.
- Holding a button gives exactly one press; it must drop low for at least one cycle before the next press.
- Reset (resetn = 0 at a rising edge), including in the middle of an edit:
  - State → `IDLE`, `enable` → 0, `set_*` → 8'h00, `field` → 0, `blink` → 0.
  - Blink counter → 0, `_q` registers → 1.
- The blink counter width is $clog2(BLINK_DIV). It wraps at `BLINK_DIV − 1`.

## Structure
- **Package `time_pkg`:**
  - State enum.
  - `ENABLE_SET`, `ENABLE_RUN` (4'b0000).
  - `HOUR_MAX_BCD` = 8'h23, `MINSEC_MAX_BCD` = 8'h59.
  - Field index constants.
- **Sub-module `bcd_updown`:** combinational. Inputs: 8-bit BCD value, max value, up, down. Output: 8-bit next value. Implements wrap/borrow only. Instantiated once and muxed onto the selected field.
- The FSM, edge detectors, capture/sanitise logic and blink counter stay in `time_setter`.

## Test plan
- **Enter edit:** reset, then `cur_h/m/s` = 8'h13/8'h45/8'h07 and pulse `btn_mode` → next cycle `enable` = 4'b0100, `set_*` = 8'h13/8'h45/8'h07, `field` = 0, `blink` = 0.
- **Hour wrap:** in `EDIT_H` with hour 8'h23, press up → 8'h00; press down → 8'h23. From 8'h19, press up → 8'h20.
- **Minute/second wrap:** press next → `field` = 1. Minute 8'h59 up → 8'h00, 8'h00 down → 8'h59. Press next twice → `field` = 0 (wraps S → H).
- **Simultaneous presses and held button:**
  - up + down in one cycle → value unchanged.
  - mode + up → `IDLE`, value unchanged.
  - `btn_up` held 10 cycles → exactly one increment.
- **Exit edit:** set 8'h09/8'h30/8'h00, press mode → `enable` = 0 next cycle, `set_*` held; a connected counter model runs from 09:30:00.
- **Reset cases:**
  - Reset in `EDIT_S` → `IDLE`, all outputs at reset values next cycle.
  - `btn_mode` held high across reset release → no edit entry.
  - `cur_h` = 8'h24 captured → `set_hour` = 8'h00.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types and constants for the time-entry controller: edit states,
// counter enable codes, BCD field limits and capture sanitisation.
package time_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT_H = 2'd1,
      EDIT_M = 2'd2,
      EDIT_S = 2'd3
   } state_t;

   localparam logic [3:0] ENABLE_SET = 4'b0100;
   localparam logic [3:0] ENABLE_RUN = 4'b0000;

   localparam logic [7:0] HOUR_MAX_BCD   = 8'h23;
   localparam logic [7:0] MINSEC_MAX_BCD = 8'h59;

   localparam logic [1:0] FIELD_HOUR   = 2'd0;
   localparam logic [1:0] FIELD_MINUTE = 2'd1;
   localparam logic [1:0] FIELD_SECOND = 2'd2;

   // Valid packed BCD orders the same way as binary, so a plain compare
   // against the BCD maximum is enough once both digits are known valid.
   function automatic logic [7:0] bcd_sanitise(input logic [7:0] value,
                                               input logic [7:0] max_value);
      if (value[7:4] > 4'd9 || value[3:0] > 4'd9 || value > max_value)
         return 8'h00;
      return value;
   endfunction

endpackage

// File: rtl/time_setter_bcd_updown.sv
// Combinational one-step packed-BCD increment/decrement with wrap at 00 and
// at a caller-supplied maximum. Up and down together leave the value alone.
module bcd_updown (
   input  logic [7:0] value,
   input  logic [7:0] max_value,
   input  logic       up,
   input  logic       down,
   output logic [7:0] next_value
);

   always_comb begin
      next_value = value;
      if (up && !down) begin
         if (value == max_value)
            next_value = 8'h00;
         else if (value[3:0] == 4'd9)
            next_value = {value[7:4] + 4'd1, 4'd0};
         else
            next_value = {value[7:4], value[3:0] + 4'd1};
      end else if (down && !up) begin
         if (value == 8'h00)
            next_value = max_value;
         else if (value[3:0] == 4'd0)
            next_value = {value[7:4] - 4'd1, 4'd9};
         else
            next_value = {value[7:4], value[3:0] - 4'd1};
      end
   end

endmodule

// File: rtl/time_setter.sv
// Button-driven hour/minute/second editor that freezes the RTC counter via
// its enable code and feeds it the edited packed-BCD time.
//
// state  | meaning
// IDLE   | counter running, set_* hold last edit, blink off
// EDIT_H | counter held at set code, hour selected
// EDIT_M | counter held at set code, minute selected
// EDIT_S | counter held at set code, second selected
module time_setter #(
   parameter int         BLINK_DIV  = 25_000_000,
   parameter logic [3:0] ENABLE_SET = time_pkg::ENABLE_SET
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       btn_mode,
   input  logic       btn_next,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [7:0] cur_h,
   input  logic [7:0] cur_m,
   input  logic [7:0] cur_s,
   output logic [3:0] enable,
   output logic [7:0] set_hour,
   output logic [7:0] set_minute,
   output logic [7:0] set_second,
   output logic [1:0] field,
   output logic       blink
);
   import time_pkg::*;

   localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

   state_t           state;
   logic             mode_q, next_q, up_q, down_q;
   logic [CNT_W-1:0] blink_cnt;
   logic             press_mode, press_next, press_up, press_down;
   logic [7:0]       sel_value, sel_max, step_value;

   // Previous-sample registers reset high so a button held through reset
   // does not look like a fresh press.
   assign press_mode = btn_mode & ~mode_q;
   assign press_next = btn_next & ~next_q;
   assign press_up   = btn_up   & ~up_q;
   assign press_down = btn_down & ~down_q;

   always_comb begin
      sel_value = set_hour;
      sel_max   = HOUR_MAX_BCD;
      case (state)
         EDIT_M: begin
            sel_value = set_minute;
            sel_max   = MINSEC_MAX_BCD;
         end
         EDIT_S: begin
            sel_value = set_second;
            sel_max   = MINSEC_MAX_BCD;
         end
         default: ;
      endcase
   end

   bcd_updown u_step (
      .value      (sel_value),
      .max_value  (sel_max),
      .up         (press_up),
      .down       (press_down),
      .next_value (step_value)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         enable     <= ENABLE_RUN;
         set_hour   <= 8'h00;
         set_minute <= 8'h00;
         set_second <= 8'h00;
         field      <= FIELD_HOUR;
         blink      <= 1'b0;
         blink_cnt  <= '0;
         mode_q     <= 1'b1;
         next_q     <= 1'b1;
         up_q       <= 1'b1;
         down_q     <= 1'b1;
      end else begin
         mode_q <= btn_mode;
         next_q <= btn_next;
         up_q   <= btn_up;
         down_q <= btn_down;

         if (state == IDLE) begin
            // Capture and enable land on the same edge so the counter
            // loads exactly the time it was showing.
            if (press_mode) begin
               state      <= EDIT_H;
               enable     <= ENABLE_SET;
               field      <= FIELD_HOUR;
               set_hour   <= bcd_sanitise(cur_h, HOUR_MAX_BCD);
               set_minute <= bcd_sanitise(cur_m, MINSEC_MAX_BCD);
               set_second <= bcd_sanitise(cur_s, MINSEC_MAX_BCD);
               blink_cnt  <= '0;
               blink      <= 1'b0;
            end
         end else if (press_mode) begin
            state     <= IDLE;
            enable    <= ENABLE_RUN;
            field     <= FIELD_HOUR;
            blink_cnt <= '0;
            blink     <= 1'b0;
         end else if (press_next) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
            case (state)
               EDIT_H: begin
                  state <= EDIT_M;
                  field <= FIELD_MINUTE;
               end
               EDIT_M: begin
                  state <= EDIT_S;
                  field <= FIELD_SECOND;
               end
               default: begin
                  state <= EDIT_H;
                  field <= FIELD_HOUR;
               end
            endcase
         end else if (press_up || press_down) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
            case (state)
               EDIT_H:  set_hour   <= step_value;
               EDIT_M:  set_minute <= step_value;
               EDIT_S:  set_second <= step_value;
               default: ;
            endcase
         end else if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
         end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: vector table, directed corner sequences, then
// randomized buttons/time checked against a decimal-arithmetic model.
module tb_time_setter;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       btn_mode = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [7:0] cur_h, cur_m, cur_s;
   logic [7:0] drv_h = 8'h13, drv_m = 8'h45, drv_s = 8'h07;
   logic       cnt_conn = 1'b0;
   int         ctr = 0;
   logic [3:0] enable;
   logic [7:0] set_hour, set_minute, set_second;
   logic [1:0] field;
   logic       blink;

   int n_tests = 0;
   int n_fail  = 0;

   time_setter #(.BLINK_DIV(DIV), .ENABLE_SET(4'b0100)) dut (
      .clk(clk), .resetn(resetn),
      .btn_mode(btn_mode), .btn_next(btn_next), .btn_up(btn_up), .btn_down(btn_down),
      .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
      .enable(enable), .set_hour(set_hour), .set_minute(set_minute),
      .set_second(set_second), .field(field), .blink(blink)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int from_bcd(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic int decode(input logic [7:0] b, input int max_v);
      if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 0;
      if (from_bcd(b) > max_v) return 0;
      return from_bcd(b);
   endfunction

   // RTC counter stand-in: one second per clock, loads set_* while held.
   always @(posedge clk) begin
      if (enable == 4'b0100)
         ctr <= from_bcd(set_hour) * 3600 + from_bcd(set_minute) * 60 + from_bcd(set_second);
      else
         ctr <= (ctr + 1) % 86400;
   end

   always_comb begin
      if (cnt_conn) begin
         cur_h = to_bcd(ctr / 3600);
         cur_m = to_bcd((ctr / 60) % 60);
         cur_s = to_bcd(ctr % 60);
      end else begin
         cur_h = drv_h;
         cur_m = drv_m;
         cur_s = drv_s;
      end
   end

   // Reference model: decimal field values, field index, cycles since blank.
   bit       m_edit = 0;
   int       m_fld = 0, m_h = 0, m_m = 0, m_s = 0, m_j = 0;
   bit [3:0] m_prev = 4'hF;

   task automatic model_step();
      bit [3:0] b, p;
      int lim;
      b = {btn_mode, btn_next, btn_up, btn_down};
      p = b & ~m_prev;
      if (!resetn) begin
         m_edit = 0; m_fld = 0; m_h = 0; m_m = 0; m_s = 0; m_j = 0; m_prev = 4'hF;
         return;
      end
      if (!m_edit) begin
         if (p[3]) begin
            m_edit = 1; m_fld = 0; m_j = 0;
            m_h = decode(cur_h, 23); m_m = decode(cur_m, 59); m_s = decode(cur_s, 59);
         end
      end else if (p[3]) begin
         m_edit = 0; m_j = 0;
      end else if (p[2]) begin
         m_fld = (m_fld + 1) % 3; m_j = 0;
      end else if (p[1] || p[0]) begin
         m_j = 0;
         if (p[1] != p[0]) begin
            lim = (m_fld == 0) ? 24 : 60;
            case (m_fld)
               0: m_h = p[1] ? (m_h + 1) % lim : (m_h + lim - 1) % lim;
               1: m_m = p[1] ? (m_m + 1) % lim : (m_m + lim - 1) % lim;
               default: m_s = p[1] ? (m_s + 1) % lim : (m_s + lim - 1) % lim;
            endcase
         end
      end else begin
         m_j++;
      end
      m_prev = b;
   endtask

   function automatic logic [30:0] model_out();
      return {m_edit ? 4'b0100 : 4'b0000, to_bcd(m_h), to_bcd(m_m), to_bcd(m_s),
              m_edit ? 2'(m_fld) : 2'd0, m_edit && ((m_j / DIV) % 2 == 1)};
   endfunction

   function automatic logic [30:0] dut_out();
      return {enable, set_hour, set_minute, set_second, field, blink};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_btn(input logic [3:0] b);
      {btn_mode, btn_next, btn_up, btn_down} = b;
   endtask

   task automatic pulse(input logic [3:0] b);
      set_btn(b);
      tick();
      set_btn(4'b0000);
      tick();
   endtask

   typedef struct {
      string      name;
      logic [3:0] btn;
      logic [3:0] en;
      logic [7:0] h, m, s;
      logic [1:0] f;
   } vec_t;

   function automatic vec_t mk(input string n, input logic [3:0] b, input logic [3:0] e,
                               input logic [7:0] h, input logic [7:0] m,
                               input logic [7:0] s, input logic [1:0] f);
      vec_t v;
      v.name = n; v.btn = b; v.en = e; v.h = h; v.m = m; v.s = s; v.f = f;
      return v;
   endfunction

   vec_t vecs[20];

   initial begin
      // button bits: {mode, next, up, down}; blink stays 0 throughout
      vecs[0]  = mk("enter",      4'b1000, 4'h4, 8'h13, 8'h45, 8'h07, 2'd0);
      vecs[1]  = mk("enter_hold", 4'b0000, 4'h4, 8'h13, 8'h45, 8'h07, 2'd0);
      vecs[2]  = mk("hour_up",    4'b0010, 4'h4, 8'h14, 8'h45, 8'h07, 2'd0);
      vecs[3]  = mk("rel0",       4'b0000, 4'h4, 8'h14, 8'h45, 8'h07, 2'd0);
      vecs[4]  = mk("next_m",     4'b0100, 4'h4, 8'h14, 8'h45, 8'h07, 2'd1);
      vecs[5]  = mk("rel1",       4'b0000, 4'h4, 8'h14, 8'h45, 8'h07, 2'd1);
      vecs[6]  = mk("min_down",   4'b0001, 4'h4, 8'h14, 8'h44, 8'h07, 2'd1);
      vecs[7]  = mk("rel2",       4'b0000, 4'h4, 8'h14, 8'h44, 8'h07, 2'd1);
      vecs[8]  = mk("up_and_dn",  4'b0011, 4'h4, 8'h14, 8'h44, 8'h07, 2'd1);
      vecs[9]  = mk("rel3",       4'b0000, 4'h4, 8'h14, 8'h44, 8'h07, 2'd1);
      vecs[10] = mk("next_s",     4'b0100, 4'h4, 8'h14, 8'h44, 8'h07, 2'd2);
      vecs[11] = mk("rel4",       4'b0000, 4'h4, 8'h14, 8'h44, 8'h07, 2'd2);
      vecs[12] = mk("sec_up",     4'b0010, 4'h4, 8'h14, 8'h44, 8'h08, 2'd2);
      vecs[13] = mk("rel5",       4'b0000, 4'h4, 8'h14, 8'h44, 8'h08, 2'd2);
      vecs[14] = mk("next_h",     4'b0100, 4'h4, 8'h14, 8'h44, 8'h08, 2'd0);
      vecs[15] = mk("rel6",       4'b0000, 4'h4, 8'h14, 8'h44, 8'h08, 2'd0);
      vecs[16] = mk("mode_up",    4'b1010, 4'h0, 8'h14, 8'h44, 8'h08, 2'd0);
      vecs[17] = mk("rel7",       4'b0000, 4'h0, 8'h14, 8'h44, 8'h08, 2'd0);
      vecs[18] = mk("idle_up",    4'b0010, 4'h0, 8'h14, 8'h44, 8'h08, 2'd0);
      vecs[19] = mk("rel8",       4'b0000, 4'h0, 8'h14, 8'h44, 8'h08, 2'd0);

      resetn = 1'b0;
      tick();
      tick();
      check("reset_state", dut_out(), 31'h0);
      resetn = 1'b1;
      tick();

      foreach (vecs[i]) begin
         set_btn(vecs[i].btn);
         tick();
         check(vecs[i].name, dut_out(),
               {vecs[i].en, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].f, 1'b0});
      end

      // hour wrap and carries
      pulse(4'b1000);
      check("reenter_capture", dut_out(), {4'h4, 8'h13, 8'h45, 8'h07, 2'd0, 1'b0});
      repeat (10) pulse(4'b0010);
      check("hour_to_23", set_hour, 8'h23);
      pulse(4'b0010);
      check("hour_23_up", set_hour, 8'h00);
      pulse(4'b0001);
      check("hour_00_dn", set_hour, 8'h23);
      repeat (4) pulse(4'b0001);
      check("hour_to_19", set_hour, 8'h19);
      pulse(4'b0010);
      check("hour_19_up", set_hour, 8'h20);
      repeat (11) pulse(4'b0001);
      check("hour_to_09", set_hour, 8'h09);
      pulse(4'b0010);
      check("hour_09_up", set_hour, 8'h10);

      // minute wrap and field rotation
      pulse(4'b0100);
      check("field_min", field, 2'd1);
      repeat (14) pulse(4'b0010);
      check("min_to_59", set_minute, 8'h59);
      pulse(4'b0010);
      check("min_59_up", set_minute, 8'h00);
      pulse(4'b0001);
      check("min_00_dn", set_minute, 8'h59);
      pulse(4'b0100);
      check("field_sec", field, 2'd2);
      pulse(4'b0100);
      check("field_wrap_h", field, 2'd0);

      // blink period and press-forced blank, then a held button
      repeat (3) tick();
      check("blink_on", blink, 1'b1);
      repeat (4) tick();
      check("blink_off", blink, 1'b0);
      repeat (4) tick();
      check("blink_on2", blink, 1'b1);
      set_btn(4'b0010);
      tick();
      check("press_blanks", {set_hour, 7'd0, blink}, {8'h11, 7'd0, 1'b0});
      repeat (9) tick();
      set_btn(4'b0000);
      tick();
      check("held_one_step", set_hour, 8'h11);
      pulse(4'b1000);

      // exit into a running counter
      drv_h = 8'h09; drv_m = 8'h30; drv_s = 8'h00;
      pulse(4'b1000);
      check("enter_0930", dut_out(), {4'h4, 8'h09, 8'h30, 8'h00, 2'd0, 1'b0});
      cnt_conn = 1'b1;
      check("ctr_loaded", ctr, 34200);
      set_btn(4'b1000);
      tick();
      check("exit", dut_out(), {4'h0, 8'h09, 8'h30, 8'h00, 2'd0, 1'b0});
      set_btn(4'b0000);
      tick();
      check("ctr_run1", ctr, 34201);
      tick();
      check("ctr_run2", ctr, 34202);
      cnt_conn = 1'b0;

      // reset in EDIT_S
      pulse(4'b1000);
      pulse(4'b0100);
      pulse(4'b0100);
      check("in_edit_s", {enable, field}, {4'h4, 2'd2});
      resetn = 1'b0;
      tick();
      check("reset_mid_edit", dut_out(), 31'h0);
      resetn = 1'b1;
      tick();

      // mode held across reset release, then sanitised capture
      btn_mode = 1'b1;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      tick();
      check("held_mode_no_entry", dut_out(), 31'h0);
      btn_mode = 1'b0;
      tick();
      drv_h = 8'h24; drv_m = 8'h5A; drv_s = 8'h07;
      pulse(4'b1000);
      check("sanitise", dut_out(), {4'h4, 8'h00, 8'h00, 8'h07, 2'd0, 1'b0});
      pulse(4'b1000);

      // randomized against the model
      for (int i = 0; i < 3000; i++) begin
         resetn = ($urandom_range(0, 199) != 0);
         btn_mode = ($urandom_range(0, 7) == 0);
         btn_next = ($urandom_range(0, 5) == 0);
         btn_up   = ($urandom_range(0, 4) == 0);
         btn_down = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 1) == 0) begin
            drv_h = to_bcd($urandom_range(0, 23));
            drv_m = to_bcd($urandom_range(0, 59));
            drv_s = to_bcd($urandom_range(0, 59));
         end else begin
            drv_h = 8'($urandom());
            drv_m = 8'($urandom());
            drv_s = 8'($urandom());
         end
         tick();
         check("random", dut_out(), model_out());
      end

      resetn = 1'b1;
      set_btn(4'b0000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
